// File: rtl/up_down_mon_pkg.sv
// Shared types and constants for the up/down count monitor.
// Optional statistics counters are enabled with the MONITOR_STATS_EN macro.
package up_down_mon_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACQUIRE    = 2'd1,
        TRACK_UP   = 2'd2,
        TRACK_DOWN = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        STEP_UP = 2'd0,
        STEP_DN = 2'd1,
        HOLD    = 2'd2,
        JUMP    = 2'd3
    } step_class_t;

endpackage

// File: rtl/up_down_mon_classifier.sv
// Combinational step classifier: compares the previous sample with the
// current one and reports the kind of step plus whether it crossed the
// max/0 boundary.
module up_down_mon_classifier
    import up_down_mon_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_class_t      step,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] delta;

    // Modular difference decides the class; wrap only qualifies single steps.
    always_comb begin
        delta = count_in - prev;
        step  = JUMP;
        wrap  = 1'b0;
        if (delta == ONE_VAL) begin
            step = STEP_UP;
            wrap = (prev == MAX_VAL);
        end else if (delta == MAX_VAL) begin
            step = STEP_DN;
            wrap = (prev == ZERO_VAL);
        end else if (delta == ZERO_VAL) begin
            step = HOLD;
        end
    end

endmodule

// File: rtl/up_down_count_monitor.sv
// Passive monitor for an up/down counter bus. Tracks direction, flags
// wraps, loads (jumps) and stalls. Define MONITOR_STATS_EN to build the
// saturating reversal/jump counters; otherwise those ports read zero.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | first edge after reset: capture sample, no classification
// ACQUIRE    | direction unknown, waiting for a single up/down step
// TRACK_UP   | counter observed stepping up
// TRACK_DOWN | counter observed stepping down
module up_down_count_monitor
    import up_down_mon_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_valid,
    output logic             dir_up,
    output logic             wrap_pulse,
    output logic             jump_pulse,
    output logic             stall_flag,
    output logic [CNT_W-1:0] dir_change_count,
    output logic [CNT_W-1:0] jump_count
);

    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mon_state_t       state;
    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    step_class_t      step;
    logic             wrap;

    up_down_mon_classifier #(
        .WIDTH (WIDTH)
    ) u_classifier (
        .prev     (prev),
        .count_in (count_in),
        .step     (step),
        .wrap     (wrap)
    );

    // Consecutive-equal-sample counter; the capture edge does not classify.
    always_comb begin
        hold_next = '0;
        if (state == IDLE) begin
            hold_next = hold_cnt;
        end else if (step == HOLD) begin
            hold_next = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
        end
    end

    // Direction FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= '0;
            hold_cnt   <= '0;
            dir_valid  <= 1'b0;
            dir_up     <= 1'b0;
            wrap_pulse <= 1'b0;
            jump_pulse <= 1'b0;
            stall_flag <= 1'b0;
        end else begin
            prev       <= count_in;
            hold_cnt   <= hold_next;
            stall_flag <= (hold_next >= STALL_TH);
            wrap_pulse <= 1'b0;
            jump_pulse <= 1'b0;
            if (state == IDLE) begin
                state     <= ACQUIRE;
                dir_valid <= 1'b0;
            end else begin
                // A wrapping single step counts in every classifying state,
                // including a reversal that happens to cross the boundary.
                wrap_pulse <= wrap;
                case (step)
                    STEP_UP: begin
                        state     <= TRACK_UP;
                        dir_valid <= 1'b1;
                        dir_up    <= 1'b1;
                    end
                    STEP_DN: begin
                        state     <= TRACK_DOWN;
                        dir_valid <= 1'b1;
                        dir_up    <= 1'b0;
                    end
                    HOLD: begin
                        state <= state;
                    end
                    default: begin
                        state      <= ACQUIRE;
                        dir_valid  <= 1'b0;
                        jump_pulse <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef MONITOR_STATS_EN
    logic reversal;
    logic jump_evt;

    assign reversal = ((state == TRACK_UP) && (step == STEP_DN)) ||
                      ((state == TRACK_DOWN) && (step == STEP_UP));
    assign jump_evt = (state != IDLE) && (step == JUMP);

    // Saturating statistics; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_change_count <= '0;
            jump_count       <= '0;
        end else begin
            if (reversal && (dir_change_count != CNT_MAX)) begin
                dir_change_count <= dir_change_count + CNT_W'(1);
            end
            if (jump_evt && (jump_count != CNT_MAX)) begin
                jump_count <= jump_count + CNT_W'(1);
            end
        end
    end
`else
    assign dir_change_count = '0;
    assign jump_count       = '0;
`endif

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Self-checking bench for up_down_count_monitor (WIDTH=4, STALL_LIMIT=8).
// Statistics expectations follow MONITOR_STATS_EN.
module tb_up_down_count_monitor;

    localparam int W  = 4;
    localparam int SL = 8;
    localparam int M  = 1 << W;
`ifdef MONITOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] count_in = W'(5);
    logic         dir_valid, dir_up, wrap_pulse, jump_pulse, stall_flag;
    logic [7:0]   dir_change_count, jump_count;

    int n_cmp = 0;
    int n_err = 0;

    up_down_count_monitor #(.WIDTH(W), .STALL_LIMIT(SL)) dut (
        .clk              (clk),
        .reset            (reset),
        .count_in         (count_in),
        .dir_valid        (dir_valid),
        .dir_up           (dir_up),
        .wrap_pulse       (wrap_pulse),
        .jump_pulse       (jump_pulse),
        .stall_flag       (stall_flag),
        .dir_change_count (dir_change_count),
        .jump_count       (jump_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: 0 = waiting for first sample, 1 = direction unknown,
    // 2 = going up, 3 = going down.
    int m_mode = 0;
    int m_prev = 0;
    int m_hold = 0;
    int m_dcc  = 0;
    int m_jc   = 0;
    bit e_dv, e_up, e_wrap, e_jump, e_stall;

    always @(posedge clk) begin
        int d;
        if (!reset) begin
            m_mode = 0; m_prev = 0; m_hold = 0; m_dcc = 0; m_jc = 0;
            e_dv = 0; e_up = 0; e_wrap = 0; e_jump = 0; e_stall = 0;
        end else if (m_mode == 0) begin
            m_prev = int'(count_in);
            m_mode = 1;
            e_dv = 0; e_wrap = 0; e_jump = 0;
            e_stall = (m_hold >= SL - 1);
        end else begin
            d = (int'(count_in) - m_prev + M) % M;
            e_wrap = 0;
            e_jump = 0;
            if (d == 0) begin
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            end else begin
                m_hold = 0;
                if (d == 1) begin
                    e_wrap = (m_prev == M - 1);
                    if (m_mode == 3 && m_dcc < 255) m_dcc++;
                    m_mode = 2;
                end else if (d == M - 1) begin
                    e_wrap = (m_prev == 0);
                    if (m_mode == 2 && m_dcc < 255) m_dcc++;
                    m_mode = 3;
                end else begin
                    e_jump = 1;
                    if (m_jc < 255) m_jc++;
                    m_mode = 1;
                end
            end
            m_prev  = int'(count_in);
            e_dv    = (m_mode >= 2);
            e_up    = (m_mode == 2);
            e_stall = (m_hold >= SL - 1);
        end
        #1;
        check("dir_valid", dir_valid, e_dv);
        if (e_dv) check("dir_up", dir_up, e_up);
        check("wrap_pulse", wrap_pulse, e_wrap);
        check("jump_pulse", jump_pulse, e_jump);
        check("stall_flag", stall_flag, e_stall);
        check("dir_change_count", dir_change_count, STATS ? m_dcc : 0);
        check("jump_count", jump_count, STATS ? m_jc : 0);
    end

    task automatic drive(input int v);
        @(negedge clk);
        count_in = W'(v);
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Held in reset with a non-zero bus value.
        repeat (3) @(posedge clk);
        #2;
        check("rst_dir_valid", dir_valid, 0);
        check("rst_dir_up", dir_up, 0);
        check("rst_wrap", wrap_pulse, 0);
        check("rst_jump", jump_pulse, 0);
        check("rst_stall", stall_flag, 0);
        check("rst_dcc", dir_change_count, 0);
        check("rst_jc", jump_count, 0);

        // Release; first edge is the capture of 5.
        @(negedge clk);
        reset = 1'b1;
        count_in = W'(5);
        @(posedge clk);
        #2;
        check("capture_dv", dir_valid, 0);
        drive(6);
        check("acq_dv", dir_valid, 1);
        check("acq_up", dir_up, 1);
        drive(7);
        check("acq_no_jump", jump_pulse, 0);

        // Up through the max->0 boundary.
        for (int v = 8; v <= 14; v++) drive(v);
        drive(15);
        check("pre_wrap", wrap_pulse, 0);
        drive(0);
        check("wrap_up", wrap_pulse, 1);
        check("wrap_no_jump", jump_pulse, 0);
        check("wrap_dir_up", dir_up, 1);
        drive(1);
        check("wrap_one_cycle", wrap_pulse, 0);

        // Reversal.
        drive(2); drive(3); drive(4); drive(3);
        check("rev_dir_up", dir_up, 0);
        check("rev_dcc", dir_change_count, STATS ? 1 : 0);
        drive(2); drive(1);
        check("rev_dcc_stable", dir_change_count, STATS ? 1 : 0);
        check("rev_dir_down", dir_up, 0);

        // Load-style jump (reversal at 1->2 first).
        drive(2); drive(3); drive(4);
        drive(10);
        check("jump_pulse", jump_pulse, 1);
        check("jump_dv", dir_valid, 0);
        check("jump_jc", jump_count, STATS ? 1 : 0);
        drive(11);
        check("post_jump_pulse", jump_pulse, 0);
        check("post_jump_dv", dir_valid, 1);
        check("post_jump_up", dir_up, 1);

        // Stall: 7 held for eight consecutive samples.
        drive(6);
        drive(7);
        for (int i = 0; i < 6; i++) drive(7);
        check("stall_7th", stall_flag, 0);
        drive(7);
        check("stall_8th", stall_flag, 1);
        drive(8);
        check("stall_clear", stall_flag, 0);
        check("stall_dir_up", dir_up, 1);
        check("stall_dv", dir_valid, 1);

        // Reset mid TRACK_DOWN, between edges.
        drive(7); drive(6);
        check("pre_rst_down", dir_up, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_dv", dir_valid, 0);
        check("async_dir_up", dir_up, 0);
        check("async_stall", stall_flag, 0);
        check("async_dcc", dir_change_count, 0);
        check("async_jc", jump_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        count_in = W'(9);
        @(posedge clk);
        #2;
        drive(8);
        check("reacq_dv", dir_valid, 1);
        check("reacq_down", dir_up, 0);
        check("reacq_dcc", dir_change_count, 0);

        // Back-to-back jumps, then a down wrap.
        drive(3);
        check("b2b_jump_a", jump_pulse, 1);
        drive(12);
        check("b2b_jump_b", jump_pulse, 1);
        drive(1);
        drive(0);
        check("dn_no_wrap", wrap_pulse, 0);
        drive(15);
        check("wrap_down", wrap_pulse, 1);
        check("wrap_down_dir", dir_up, 0);
        drive(14);
        check("wrap_down_end", wrap_pulse, 0);

        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/up_down_count_monitor.md
# up_down_count_monitor

Passive observer on the output bus of the 4-bit up/down counter with parallel load. It samples the count every clock and classifies each step as increment, decrement, hold or discontinuity (load). It tracks the current counting direction through a small state machine and flags wrap-around, loads and stalls. It sits beside the counter in the design and in benches as the receiving end of the count bus, giving a self-checking view of counter behaviour.

## Interface
- WIDTH, 4: width of the observed count; must be ≥ 2.
- STALL_LIMIT, 8: number of consecutive equal samples that raises stall_flag; range 2..255.
- clk  input  1  sole clock; all logic samples on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- count_in  input  WIDTH  observed counter value, sampled every rising edge.
- dir_valid  output  1  direction is known (state TRACK_UP or TRACK_DOWN).
- dir_up  output  1  1 = counting up, 0 = counting down; meaningful only when dir_valid = 1.
- wrap_pulse  output  1  one-cycle pulse on a max→0 step (up) or a 0→max step (down).
- jump_pulse  output  1  one-cycle pulse on a step that is not +1, −1 or 0.
- stall_flag  output  1  count has held for at least STALL_LIMIT consecutive samples.
- dir_change_count  output  8  saturating count of direction reversals.
- jump_count  output  8  saturating count of jumps.

## Operation
- Registers:
  - prev (WIDTH bits): last sample.
  - state: IDLE, ACQUIRE, TRACK_UP, TRACK_DOWN.
  - hold_cnt (8 bits): saturating count of consecutive equal samples.
- delta = (count_in − prev) mod 2^WIDTH. Classification:
  - +1 is STEP_UP.
  - 2^WIDTH − 1 is STEP_DN.
  - 0 is HOLD.
  - Any other value is JUMP.
- IDLE: the first edge after reset release loads prev with count_in and moves to ACQUIRE. No classification occurs on this edge.
- ACQUIRE:
  - STEP_UP → TRACK_UP.
  - STEP_DN → TRACK_DOWN.
  - HOLD → stay in ACQUIRE.
  - JUMP → stay in ACQUIRE, pulse jump_pulse, increment jump_count.
- TRACK_UP:
  - STEP_UP → stay.
  - STEP_DN → TRACK_DOWN, increment dir_change_count.
  - HOLD → stay.
  - JUMP → ACQUIRE, jump_pulse, increment jump_count.
- TRACK_DOWN: mirror image of TRACK_UP.
- Wrap:
  - In TRACK_UP or ACQUIRE, a STEP_UP with prev = 2^WIDTH − 1 pulses wrap_pulse.
  - In TRACK_DOWN or ACQUIRE, a STEP_DN with prev = 0 pulses wrap_pulse.
  - A wrap is never a jump.
- A reversal whose step also wraps asserts wrap_pulse and increments dir_change_count on the same edge.
- Hold counting:
  - HOLD increments hold_cnt (saturating at 255).
  - Any non-HOLD step clears hold_cnt.
  - stall_flag = 1 while hold_cnt ≥ STALL_LIMIT − 1, i.e. on the STALL_LIMIT-th consecutive equal sample including the first. It clears on the edge of the next change.
- A stall does not change state or direction.
- dir_change_count and jump_count saturate at 255 and clear only on reset.
- prev is updated with count_in on every edge outside reset.

## Timing
- All outputs are registered. A step sampled at edge k is reflected in the outputs from edge k until edge k+1, giving one cycle of latency from the sample.
- wrap_pulse and jump_pulse are exactly one clock wide. Back-to-back qualifying steps give back-to-back pulses.
- Reset asserted (low), at any time, immediately forces:
  - state = IDLE, prev = 0, hold_cnt = 0.
  - all outputs 0, both counters 0.
- Reset assertion mid-TRACK discards direction.
- After reset deasserts, the first rising edge is the IDLE capture. The earliest possible dir_valid is after the second edge.

## Configuration
- MONITOR_STATS_EN defined: dir_change_count and jump_count registers and their increment logic are built as described.
- MONITOR_STATS_EN undefined: both ports remain and are tied to 8'd0. All other behaviour is unchanged.

## Structure
- Package up_down_mon_pkg holds:
  - the state enum (IDLE, ACQUIRE, TRACK_UP, TRACK_DOWN);
  - the step-class enum (STEP_UP, STEP_DN, HOLD, JUMP);
  - the counter width constant (8).
- Sub-module up_down_mon_classifier is a combinational block that takes prev and count_in and produces the step class and a wrap indication.
- The top level holds the FSM, hold counter, statistics and output registers.

## Test plan
All scenarios use WIDTH = 4 and STALL_LIMIT = 8.
- Reset low with count_in = 5 → all outputs 0. Release and drive 5, 6, 7 → dir_valid = 1 and dir_up = 1 starting one cycle after 6 is sampled. No pulses.
- Up sequence 14, 15, 0, 1 → wrap_pulse high for exactly the one cycle following the 0 sample. jump_pulse stays 0 and dir_up stays 1.
- Tracking up 3, 4, then 3 → dir_up falls to 0 and dir_change_count goes 0 → 1. Then 2, 1 → no further change.
- Load-style jump 4 → 10 → jump_pulse for one cycle, dir_valid = 0, jump_count = 1. Then 11 → dir_valid = 1, dir_up = 1.
- Hold at 7 for 8 consecutive samples → stall_flag asserts on the 8th sample. Next sample 8 → stall_flag clears and dir_up stays 1.
- In TRACK_DOWN, assert reset between edges → all outputs go to 0 immediately without waiting for a clock edge. After release, 9, 8 → TRACK_DOWN re-acquired with dir_change_count = 0.
